uart_tx_engine: RTL and testbench
=================================

// Module: uart_tx_engine
// PURPOSE
//   Serial UART transmitter: takes one parallel word per valid/ready handshake and
//   shifts it out LSB-first on o_uart_tx as start/data/[parity]/stop bits.
//   Sits beside the receive path, driven by user logic on the 50MHz PLL clock
//   with reset = ~locked. Frame format is fixed at elaboration by parameters.
// PARAMETERS
//   P_SYSTEM_CLK       50_000_000  input clock frequency, Hz
//   P_UART_BUADRATE    9600        baud rate; bit period DIV = P_SYSTEM_CLK/P_UART_BUADRATE (truncated), DIV>=2
//   P_UART_DATA_WIDTH  8           data bits per frame, legal 5..8
//   P_UART_STOP_WIDTH  1           stop bits, legal 1 or 2
//   P_UART_CHECK       0           parity: 0=NONE, 1=ODD, 2=EVEN
// PORTS
//   i_clk            in   1   system clock; all logic on rising edge
//   i_rst            in   1   synchronous reset, active-high
//   i_user_tx_data   in   P_UART_DATA_WIDTH  word to send
//   i_user_tx_valid  in   1   i_user_tx_data valid
//   o_user_tx_ready  out  1   engine idle, can accept a word this cycle
//   o_uart_tx        out  1   serial line, idle high
//   o_tx_busy        out  1   frame in progress (= ~o_user_tx_ready)
// BEHAVIOUR
//   Reset (i_rst high at edge): state=IDLE, o_uart_tx=1, o_user_tx_ready=1,
//     o_tx_busy=0, baud/bit counters=0, shift register=0. Reset mid-frame aborts
//     frame at that edge; line returns high, no partial stop bits sent.
//   All outputs registered; no combinational path input->output.
//   Handshake: transfer when i_user_tx_valid & o_user_tx_ready at an edge; data
//     latched at that edge. valid while ready=0 is ignored (no queueing);
//     i_user_tx_data may change freely after transfer.
//   FSM: IDLE -> START -> DATA -> PARITY (only if P_UART_CHECK!=0) -> STOP -> IDLE.
//     IDLE : line 1, ready 1. On transfer: -> START, line<=0, ready<=0.
//     START: hold 0 for DIV cycles, then -> DATA with line<=data[0].
//     DATA : each bit held DIV cycles, LSB first; after bit W-1 -> PARITY or STOP.
//     PARITY: ODD: bit = ~^data (total ones incl. parity odd); EVEN: ^data. DIV cycles.
//     STOP : line 1 for P_UART_STOP_WIDTH*DIV cycles, then -> IDLE, ready<=1.
//   Baud counter counts 0..DIV-1 per bit, resets at each bit boundary; bit
//     counter width ceil(log2(W)); no drift across bits.
//   Latency: first start-bit cycle is the cycle after transfer edge. ready returns
//     1 exactly (1+W+P+S)*DIV cycles after transfer edge (P=0/1, S=stop bits).
//   Back-to-back: valid held high -> next transfer on first cycle ready=1, so
//     ready is high exactly one cycle; gap between frames = 1 clock of idle high
//     beyond the stop bits.
//   Illegal params (W outside 5..8, S not 1/2, CHECK>2, DIV<2) -> elaboration error.
// TESTING (sim override P_SYSTEM_CLK=160, P_UART_BUADRATE=10 -> DIV=16)
//   Reset: i_rst=1 for 3 cycles -> o_uart_tx=1, ready=1, busy=0 every cycle.
//   8N1, send 0x55 -> line 0,1,0,1,0,1,0,1,0,1 each 16 clk; ready=1 after 160 clk.
//   8O1 send 0x07 -> parity bit 0; 8E2 send 0x07 -> parity 1, stop high 32 clk,
//     ready after 192 clk.
//   valid held high, data 0xA5 then 0x3C -> two frames, 1-clk ready pulse between,
//     valid pulses while busy produce no extra frame.
//   i_rst asserted at cycle 40 of frame -> next edge line=1, ready=1; new 0xFF sent
//     cleanly afterwards (start 16 clk low, 8x16 clk high).
//   7N1 (W=7) send 0x80 -> only bits [6:0] sent (all 0), frame 144 clk.

Source files
------------

// File: rtl/uart_tx_engine.sv
// -----------------------------------------------------------------------------
// uart_tx_engine
//   Serial UART transmitter. Accepts one parallel word per valid/ready
//   handshake and shifts it out LSB-first as start / data / [parity] / stop
//   bits. The frame format is fixed at elaboration by the parameters.
//
// Handshake (valid/ready):
//   A word transfers on a rising edge where i_user_tx_valid and
//   o_user_tx_ready are both high; i_user_tx_data is captured on that edge.
//   Valid while ready is low is ignored (nothing is queued). The source may
//   change or drop data/valid freely once the transfer edge has passed.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_rst            synchronous reset, active-high
//   i_user_tx_data   word to send (P_UART_DATA_WIDTH bits)
//   i_user_tx_valid  i_user_tx_data is valid
//   o_user_tx_ready  engine idle, a word can be accepted this cycle
//   o_uart_tx        serial line, idle high
//   o_tx_busy        frame in progress (always ~o_user_tx_ready)
//   o_fsm_state      current FSM state, for debug/observation
// -----------------------------------------------------------------------------
module uart_tx_engine #(
    parameter int P_SYSTEM_CLK      = 50_000_000,
    parameter int P_UART_BUADRATE   = 9600,
    parameter int P_UART_DATA_WIDTH = 8,
    parameter int P_UART_STOP_WIDTH = 1,
    parameter int P_UART_CHECK      = 0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [P_UART_DATA_WIDTH-1:0] i_user_tx_data,
    input  logic                         i_user_tx_valid,
    output logic                         o_user_tx_ready,
    output logic                         o_uart_tx,
    output logic                         o_tx_busy,
    output logic [2:0]                   o_fsm_state
);

    localparam int DIV   = P_SYSTEM_CLK / P_UART_BUADRATE;
    localparam int W     = P_UART_DATA_WIDTH;
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int BIT_W = (W > 2) ? $clog2(W) : 1;

    // Reject frame formats the logic below does not support.
    if (W < 5 || W > 8) begin : g_bad_width
        $error("uart_tx_engine: P_UART_DATA_WIDTH must be 5..8");
    end
    if (P_UART_STOP_WIDTH < 1 || P_UART_STOP_WIDTH > 2) begin : g_bad_stop
        $error("uart_tx_engine: P_UART_STOP_WIDTH must be 1 or 2");
    end
    if (P_UART_CHECK < 0 || P_UART_CHECK > 2) begin : g_bad_check
        $error("uart_tx_engine: P_UART_CHECK must be 0, 1 or 2");
    end
    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_engine: clock/baud ratio must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   baud_q,  baud_d;
    logic [BIT_W-1:0]   bit_q,   bit_d;
    logic [W-1:0]       data_q,  data_d;
    logic               line_q,  line_d;
    logic               ready_q, ready_d;
    logic               busy_q;

    logic               baud_end;
    logic               parity_bit;
    logic [BIT_W-1:0]   bit_next;

    assign baud_end   = (baud_q == CNT_W'(DIV - 1));
    assign bit_next   = bit_q + BIT_W'(1);
    // ODD makes the total count of ones (data + parity) odd; EVEN makes it even.
    assign parity_bit = (P_UART_CHECK == 1) ? ~(^data_q) : (^data_q);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        data_d  = data_q;
        line_d  = line_q;
        ready_d = ready_q;

        case (state_q)
            S_IDLE: begin
                baud_d  = '0;
                bit_d   = '0;
                line_d  = 1'b1;
                ready_d = 1'b1;
                if (i_user_tx_valid && ready_q) begin
                    state_d = S_START;
                    data_d  = i_user_tx_data;
                    line_d  = 1'b0;
                    ready_d = 1'b0;
                end
            end

            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                    line_d  = data_q[0];
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == BIT_W'(W - 1)) begin
                        bit_d = '0;
                        if (P_UART_CHECK != 0) begin
                            state_d = S_PARITY;
                            line_d  = parity_bit;
                        end else begin
                            state_d = S_STOP;
                            line_d  = 1'b1;
                        end
                    end else begin
                        bit_d  = bit_next;
                        line_d = data_q[bit_next];
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end

            S_PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_STOP;
                    line_d  = 1'b1;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end

            S_STOP: begin
                // bit_q counts stop bits here so each one gets a full DIV period.
                line_d = 1'b1;
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == BIT_W'(P_UART_STOP_WIDTH - 1)) begin
                        bit_d   = '0;
                        state_d = S_IDLE;
                        ready_d = 1'b1;
                    end else begin
                        bit_d = bit_next;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                bit_d   = '0;
                line_d  = 1'b1;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            line_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            line_q  <= line_d;
            ready_q <= ready_d;
            busy_q  <= ~ready_d;
        end
    end

    assign o_uart_tx       = line_q;
    assign o_user_tx_ready = ready_q;
    assign o_tx_busy       = busy_q;
    assign o_fsm_state     = state_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_engine
//   Four engines with DIV=16 (8N1, 8O1, 8E2, 7N1) share clock and reset.
//   Each expected frame is built as a queue of line levels (one entry per bit
//   period) from the frame rules, then compared cycle by cycle.
// -----------------------------------------------------------------------------
module tb_uart_tx_engine;

    localparam int DIV = 16;
    localparam int NU  = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // per-unit frame format: data width, parity (0 none/1 odd/2 even), stop bits
    int cfg_w [NU] = '{8, 8, 8, 7};
    int cfg_p [NU] = '{0, 1, 2, 0};
    int cfg_s [NU] = '{1, 1, 2, 1};

    logic [7:0] tx_data  [NU];
    logic       tx_valid [NU];
    logic       tx_ready [NU];
    logic       uart_tx  [NU];
    logic       tx_busy  [NU];
    logic [2:0] fsm_state[NU];

    uart_tx_engine #(.P_SYSTEM_CLK(160), .P_UART_BUADRATE(10), .P_UART_DATA_WIDTH(8),
                     .P_UART_STOP_WIDTH(1), .P_UART_CHECK(0)) u_8n1 (
        .i_clk(clk), .i_rst(rst), .i_user_tx_data(tx_data[0]), .i_user_tx_valid(tx_valid[0]),
        .o_user_tx_ready(tx_ready[0]), .o_uart_tx(uart_tx[0]), .o_tx_busy(tx_busy[0]),
        .o_fsm_state(fsm_state[0]));

    uart_tx_engine #(.P_SYSTEM_CLK(160), .P_UART_BUADRATE(10), .P_UART_DATA_WIDTH(8),
                     .P_UART_STOP_WIDTH(1), .P_UART_CHECK(1)) u_8o1 (
        .i_clk(clk), .i_rst(rst), .i_user_tx_data(tx_data[1]), .i_user_tx_valid(tx_valid[1]),
        .o_user_tx_ready(tx_ready[1]), .o_uart_tx(uart_tx[1]), .o_tx_busy(tx_busy[1]),
        .o_fsm_state(fsm_state[1]));

    uart_tx_engine #(.P_SYSTEM_CLK(160), .P_UART_BUADRATE(10), .P_UART_DATA_WIDTH(8),
                     .P_UART_STOP_WIDTH(2), .P_UART_CHECK(2)) u_8e2 (
        .i_clk(clk), .i_rst(rst), .i_user_tx_data(tx_data[2]), .i_user_tx_valid(tx_valid[2]),
        .o_user_tx_ready(tx_ready[2]), .o_uart_tx(uart_tx[2]), .o_tx_busy(tx_busy[2]),
        .o_fsm_state(fsm_state[2]));

    uart_tx_engine #(.P_SYSTEM_CLK(160), .P_UART_BUADRATE(10), .P_UART_DATA_WIDTH(7),
                     .P_UART_STOP_WIDTH(1), .P_UART_CHECK(0)) u_7n1 (
        .i_clk(clk), .i_rst(rst), .i_user_tx_data(tx_data[3][6:0]), .i_user_tx_valid(tx_valid[3]),
        .o_user_tx_ready(tx_ready[3]), .o_uart_tx(uart_tx[3]), .o_tx_busy(tx_busy[3]),
        .o_fsm_state(fsm_state[3]));

    // ---------------- scoreboard ----------------
    int         cmp_cnt = 0;
    int         err_cnt = 0;
    logic [0:0] exp_q[$];   // expected line level per bit period

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference frame: start 0, data LSB first, optional parity, stop 1s.
    task automatic build_frame(input int u, input logic [7:0] d);
        int ones;
        ones = 0;
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < cfg_w[u]; i++) begin
            exp_q.push_back(1'((d >> i) & 8'd1));
            ones += int'((d >> i) & 8'd1);
        end
        if (cfg_p[u] == 1) exp_q.push_back((ones % 2 == 0) ? 1'b1 : 1'b0);
        if (cfg_p[u] == 2) exp_q.push_back((ones % 2 == 1) ? 1'b1 : 1'b0);
        for (int s = 0; s < cfg_s[u]; s++) exp_q.push_back(1'b1);
    endtask

    task automatic check_idle(input int u, input string what);
        check_eq($sformatf("u%0d %s line", u, what), 32'(uart_tx[u]), 32'd1);
        check_eq($sformatf("u%0d %s ready", u, what), 32'(tx_ready[u]), 32'd1);
        check_eq($sformatf("u%0d %s busy", u, what), 32'(tx_busy[u]), 32'd0);
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge while unit u is idle; returns at the negedge just
    // after the transfer edge.
    task automatic start_xfer(input int u, input logic [7:0] d);
        tx_data[u]  = d;
        tx_valid[u] = 1'b1;
        @(negedge clk);
    endtask

    // Checks a whole frame of unit u cycle by cycle, starting at the negedge
    // after its transfer edge. mode 0: valid low; 1: valid held high with
    // next_d on the data bus; 2: random valid/data pulses while busy.
    // abort_at >= 0 asserts reset at that cycle of the frame instead.
    task automatic run_frame(input int u, input logic [7:0] d, input int mode,
                             input logic [7:0] next_d, input int abort_at);
        int n;
        build_frame(u, d);
        n = exp_q.size() * DIV;
        for (int k = 0; k < n; k++) begin
            check_eq($sformatf("u%0d d%02h line k%0d", u, d, k), 32'(uart_tx[u]), 32'(exp_q[k / DIV]));
            check_eq($sformatf("u%0d d%02h ready k%0d", u, d, k), 32'(tx_ready[u]), 32'd0);
            check_eq($sformatf("u%0d d%02h busy k%0d", u, d, k), 32'(tx_busy[u]), 32'd1);
            if (k == abort_at) begin
                tx_valid[u] = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_idle(u, "after abort");
                return;
            end
            case (mode)
                1: begin
                    tx_valid[u] = 1'b1;
                    tx_data[u]  = next_d;
                end
                2: begin
                    tx_valid[u] = (k < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                    tx_data[u]  = 8'($urandom);
                end
                default: tx_valid[u] = 1'b0;
            endcase
            @(negedge clk);
        end
        check_idle(u, $sformatf("d%02h end", d));
    endtask

    task automatic idle_cycles(input int u, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            check_idle(u, "idle");
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] d;
        int         u;
        for (int i = 0; i < NU; i++) begin
            tx_data[i]  = 8'h00;
            tx_valid[i] = 1'b0;
        end

        // reset held for 3 cycles: all units idle every cycle
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int i = 0; i < NU; i++) check_idle(i, "reset");
        end
        rst = 1'b0;
        @(negedge clk);

        // directed frames
        start_xfer(0, 8'h55); run_frame(0, 8'h55, 0, 8'h00, -1);
        start_xfer(1, 8'h07); run_frame(1, 8'h07, 0, 8'h00, -1);
        start_xfer(2, 8'h07); run_frame(2, 8'h07, 0, 8'h00, -1);
        start_xfer(3, 8'h80); run_frame(3, 8'h80, 0, 8'h00, -1);

        // back-to-back with valid held high, then pulses while busy
        start_xfer(0, 8'hA5);
        run_frame(0, 8'hA5, 1, 8'h3C, -1);
        @(negedge clk);
        run_frame(0, 8'h3C, 2, 8'h00, -1);
        idle_cycles(0, 20);

        // reset mid-frame, then a clean frame
        d = 8'($urandom);
        start_xfer(0, d);
        run_frame(0, d, 0, 8'h00, 40);
        idle_cycles(0, 2);
        start_xfer(0, 8'hFF); run_frame(0, 8'hFF, 0, 8'h00, -1);

        // randomized frames across all formats
        for (int i = 0; i < 24; i++) begin
            u = int'($urandom_range(0, NU - 1));
            d = 8'($urandom);
            idle_cycles(u, int'($urandom_range(0, 3)));
            start_xfer(u, d);
            run_frame(u, d, ($urandom_range(0, 1) == 1) ? 2 : 0, 8'h00, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    // watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
